fetch_unit: RTL and testbench

//  Instruction-fetch datapath that feeds the accumulator-CPU controller: holds the PC and the two-part IR.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_pc_counter.sv | 35 +++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the accumulator-CPU fetch path: default widths
// (also used by the controller and memory model), opcode constants and the
// fetch phase encoding.
package fetch_unit_pkg;

    localparam int unsigned FU_AW   = 12;
    localparam int unsigned FU_DW   = 8;
    localparam int unsigned FU_CNTW = 16;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_STA = 4'b0001;
    localparam logic [3:0] OP_ADA = 4'b0010;
    localparam logic [3:0] OP_ANA = 4'b0011;

    // Position within the two-word instruction fetch.
    typedef enum logic [1:0] {
        PH_IDLE      = 2'b00,
        PH_HAVE_OP   = 2'b01,
        PH_HAVE_ADDR = 2'b10
    } phase_e;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: AW-bit register that increments (mod 2^AW) when enabled.
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset, clears the count
//   en_i  in  increment at the next rising edge
//   pc_o  out current program counter
module pc_counter #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    output logic [AW-1:0] pc_o
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            pc_d = pc_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch datapath: holds the PC and the two-word IR, drives the
// memory address mux, tracks the two-word fetch sequence, counts completed
// fetches and flags out-of-order IR writes.
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   mem_rdata      combinational memory read data at mem_addr
//   pcWrite        increment PC
//   IRwritePart1   capture word1 = {opcode, high address bits}
//   IRwritePart2   capture word2 = low address byte
//   memAddressSel  0: mem_addr = pc, 1: mem_addr = ir_addr
//   upcode         opcode field of IR
//   ir_addr        operand address {hi, lo}
//   pc             program counter
//   mem_addr       memory address (combinational)
//   addr_valid     both words of the current instruction held
//   seq_err        sticky fetch-sequence error
//   instr_count    completed two-word fetches (wraps)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned AW   = FU_AW,
    parameter int unsigned DW   = FU_DW,
    parameter int unsigned CNTW = FU_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            pcWrite,
    input  logic            IRwritePart1,
    input  logic            IRwritePart2,
    input  logic            memAddressSel,
    output logic [3:0]      upcode,
    output logic [AW-1:0]   ir_addr,
    output logic [AW-1:0]   pc,
    output logic [AW-1:0]   mem_addr,
    output logic            addr_valid,
    output logic            seq_err,
    output logic [CNTW-1:0] instr_count
);

    phase_e          phase_q, phase_d;
    logic [3:0]      upcode_q, upcode_d;
    logic [AW-DW-1:0] ir_hi_q, ir_hi_d;
    logic [DW-1:0]   ir_lo_q, ir_lo_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    pc_counter #(
        .AW(AW)
    ) u_pc (
        .clk (clk),
        .rst (rst),
        .en_i(pcWrite),
        .pc_o(pc)
    );

    always_comb begin
        phase_d  = phase_q;
        upcode_d = upcode_q;
        ir_hi_d  = ir_hi_q;
        ir_lo_d  = ir_lo_q;
        valid_d  = valid_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        if (IRwritePart1) begin
            // Part1 wins from any phase; a simultaneous Part2 is dropped and flagged.
            upcode_d = mem_rdata[DW-1:DW-4];
            ir_hi_d  = mem_rdata[DW-5:0];
            phase_d  = PH_HAVE_OP;
            valid_d  = 1'b0;
            if (IRwritePart2) begin
                err_d = 1'b1;
            end
        end else if (IRwritePart2) begin
            // The low byte is captured even when out of sequence.
            ir_lo_d = mem_rdata;
            if (phase_q == PH_HAVE_OP) begin
                phase_d = PH_HAVE_ADDR;
                valid_d = 1'b1;
                cnt_d   = cnt_q + CNTW'(1);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_IDLE;
            upcode_q <= '0;
            ir_hi_q  <= '0;
            ir_lo_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            upcode_q <= upcode_d;
            ir_hi_q  <= ir_hi_d;
            ir_lo_q  <= ir_lo_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        mem_addr = memAddressSel ? {ir_hi_q, ir_lo_q} : pc;
    end

    assign upcode      = upcode_q;
    assign ir_addr     = {ir_hi_q, ir_lo_q};
    assign addr_valid  = valid_q;
    assign seq_err     = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem_rdata;
    logic        pcWrite = 1'b0;
    logic        IRwritePart1 = 1'b0;
    logic        IRwritePart2 = 1'b0;
    logic        memAddressSel = 1'b0;
    logic [3:0]  upcode;
    logic [11:0] ir_addr;
    logic [11:0] pc;
    logic [11:0] mem_addr;
    logic        addr_valid;
    logic        seq_err;
    logic [15:0] instr_count;

    logic [7:0] mem [0:4095];

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model state, in plain integers.
    int m_pc, m_op, m_ir, m_phase, m_valid, m_err, m_cnt;  // phase: 0 idle, 1 have op, 2 have addr

    fetch_unit #(.AW(12), .DW(8), .CNTW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rdata    (mem_rdata),
        .pcWrite      (pcWrite),
        .IRwritePart1 (IRwritePart1),
        .IRwritePart2 (IRwritePart2),
        .memAddressSel(memAddressSel),
        .upcode       (upcode),
        .ir_addr      (ir_addr),
        .pc           (pc),
        .mem_addr     (mem_addr),
        .addr_valid   (addr_valid),
        .seq_err      (seq_err),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    // Memory emulation: combinational read at whatever address the DUT presents.
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic int model_addr();
        return memAddressSel ? m_ir : m_pc;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_op = 0; m_ir = 0; m_phase = 0;
            m_valid = 0; m_err = 0; m_cnt = 0;
        end else begin
            int rd;
            rd = mem[model_addr()];
            if (IRwritePart1) begin
                m_op    = rd / 16;
                m_ir    = (rd % 16) * 256 + (m_ir % 256);
                m_phase = 1;
                m_valid = 0;
                if (IRwritePart2) m_err = 1;
            end else if (IRwritePart2) begin
                m_ir = (m_ir / 256) * 256 + rd;
                if (m_phase == 1) begin
                    m_phase = 2;
                    m_valid = 1;
                    m_cnt   = (m_cnt + 1) % 65536;
                end else begin
                    m_err = 1;
                end
            end
            if (pcWrite) m_pc = (m_pc + 1) % 4096;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("pc", int'(pc), m_pc);
            chk("upcode", int'(upcode), m_op);
            chk("ir_addr", int'(ir_addr), m_ir);
            chk("mem_addr", int'(mem_addr), model_addr());
            chk("addr_valid", int'(addr_valid), m_valid);
            chk("seq_err", int'(seq_err), m_err);
            chk("instr_count", int'(instr_count), m_cnt);
        end
    end

    // Inputs applied at posedge+1, sampled by the following posedge.
    task automatic cyc(input bit pw, input bit p1, input bit p2, input bit sel);
        pcWrite = pw; IRwritePart1 = p1; IRwritePart2 = p2; memAddressSel = sel;
        @(posedge clk); #1;
        pcWrite = 1'b0; IRwritePart1 = 1'b0; IRwritePart2 = 1'b0;
    endtask

    task automatic reset_mid(input bit check_now);
        pcWrite = 1'b0; IRwritePart1 = 1'b0; IRwritePart2 = 1'b0; memAddressSel = 1'b0;
        #3 rst = 1'b1;
        #1;
        if (check_now) begin
            chk("rst_pc", int'(pc), 0);
            chk("rst_upcode", int'(upcode), 0);
            chk("rst_ir_addr", int'(ir_addr), 0);
            chk("rst_addr_valid", int'(addr_valid), 0);
            chk("rst_seq_err", int'(seq_err), 0);
            chk("rst_instr_count", int'(instr_count), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Normal fetch.
        mem[0] = 8'h2A; mem[1] = 8'h5C;
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 0);
        chk("fetch_upcode", int'(upcode), 'h2);
        chk("fetch_ir_addr", int'(ir_addr), 'hA5C);
        chk("fetch_pc", int'(pc), 2);
        chk("fetch_valid", int'(addr_valid), 1);
        chk("fetch_count", int'(instr_count), 1);

        // Address mux, same cycle.
        memAddressSel = 1'b1; #1;
        chk("mux_ir", int'(mem_addr), 'hA5C);
        memAddressSel = 1'b0; #1;
        chk("mux_pc", int'(mem_addr), 'h002);

        // Reset mid-cycle with non-zero state.
        @(posedge clk); #1;
        reset_mid(1'b1);

        // PC wrap.
        for (int i = 0; i < 4095; i++) cyc(1, 0, 0, 0);
        chk("wrap_pre", int'(pc), 'hFFF);
        cyc(1, 0, 0, 0);
        chk("wrap_post", int'(pc), 'h000);
        chk("wrap_count", int'(instr_count), 0);

        // Sequence errors.
        reset_mid(1'b0);
        cyc(0, 0, 1, 0);
        chk("err_p2_idle", int'(seq_err), 1);
        chk("err_p2_count", int'(instr_count), 0);
        chk("err_p2_valid", int'(addr_valid), 0);
        cyc(0, 1, 1, 0);
        chk("err_both_sticky", int'(seq_err), 1);
        cyc(0, 0, 1, 0);
        chk("err_both_haveop", int'(instr_count), 1);
        chk("err_both_valid", int'(addr_valid), 1);

        // Back-to-back LDA / STA / ADA.
        reset_mid(1'b0);
        mem[0] = 8'h01; mem[1] = 8'h10;
        mem[2] = 8'h12; mem[3] = 8'h20;
        mem[4] = 8'h23; mem[5] = 8'h30;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 0, 0);
            chk("b2b_valid_drop", int'(addr_valid), 0);
            chk("b2b_upcode", int'(upcode), k);
            cyc(1, 0, 1, 0);
            chk("b2b_valid", int'(addr_valid), 1);
        end
        chk("b2b_count", int'(instr_count), 3);
        chk("b2b_ir_addr", int'(ir_addr), 'h330);
        chk("b2b_seq_err", int'(seq_err), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_mid(1'b1);
            end else begin
                cyc(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
